// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand widths and the step-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DW = 8;
  localparam int DIV_VW = 4;

  // Width needed to hold a step count of DW-1 down to 0 (never less than 1 bit).
  function automatic int cnt_width(input int dw);
    return (dw <= 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift one dividend bit into the partial
// remainder, try to subtract the divisor, and keep the difference if it fits.
module div_restore_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] pr,
  input  logic          in_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] pr_next,
  output logic          q_bit
);

  logic [VW-1:0] pr_low;
  logic          ge;

  // The shifted remainder is VW+1 bits wide: pr[VW-1] is its top bit and pr_low
  // the rest. A set top bit means the value is at least 2^VW, which always
  // covers the divisor. Because the remainder entering a step is below the
  // divisor, the result of the step is below the divisor as well, so a VW-bit
  // modular subtract gives the exact result.
  always_comb begin
    pr_low  = {pr[VW-2:0], in_bit};
    ge      = pr[VW-1] | (pr_low >= divisor);
    pr_next = ge ? (pr_low - divisor) : pr_low;
    q_bit   = ge;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider producing one quotient bit per clock,
// with a start/done handshake. Optional feature macro: DIV_DBZ_FLAG_EN adds a
// div_by_zero output that flags requests made with a zero divisor.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
`ifdef DIV_DBZ_FLAG_EN
  ,
  output logic          div_by_zero
`endif
);

  localparam int CW = cnt_width(DW);

  div_state_t    state_q, state_d;
  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after DW steps this register holds the quotient.
  logic [DW-1:0] dq_q, dq_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef DIV_DBZ_FLAG_EN
  logic          dbz_q, dbz_d;
`endif

  logic [VW-1:0] step_pr;
  logic          step_q;

  div_restore_step #(
    .VW(VW)
  ) u_step (
    .pr      (pr_q),
    .in_bit  (dq_q[DW-1]),
    .divisor (dvs_q),
    .pr_next (step_pr),
    .q_bit   (step_q)
  );

  // Next-state, datapath and registered-output logic for IDLE/BUSY/DONE.
  always_comb begin
    state_d     = state_q;
    dq_d        = dq_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef DIV_DBZ_FLAG_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      BUSY: begin
        dq_d = {dq_q[DW-2:0], step_q};
        pr_d = step_pr;
        if (cnt_q == '0) begin
          state_d     = DONE;
          done_d      = 1'b1;
          quotient_d  = {dq_q[DW-2:0], step_q};
          remainder_d = step_pr;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, so back-to-back works.
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = '0;
`ifdef DIV_DBZ_FLAG_EN
            dbz_d       = 1'b1;
`endif
          end else begin
            state_d = BUSY;
            busy_d  = 1'b1;
            dq_d    = dividend;
            dvs_d   = divisor;
            pr_d    = '0;
            cnt_d   = CW'(DW - 1);
`ifdef DIV_DBZ_FLAG_EN
            dbz_d   = 1'b0;
`endif
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dq_q        <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dq_q        <= dq_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_DBZ_FLAG_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_DBZ_FLAG_EN
  assign div_by_zero = dbz_q;
`endif

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider. It is the inverse operation of the team's 4x4 array multiplier.
- Takes a DW-bit dividend and a VW-bit divisor. Produces a DW-bit quotient and a VW-bit remainder, one quotient bit per clock.
- Feeds the binary-to-BCD datapath, where repeated divide-by-10 and range checks are needed.
- Start/done handshake toward the controlling FSM.

Parameters:
- DW, 8, dividend and quotient width (>=2)
- VW, 4, divisor and remainder width (>=2, <=DW)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; operands sampled on the edge where start=1 and the block is not BUSY
- dividend  in  DW  unsigned dividend
- divisor  in  VW  unsigned divisor
- busy  out  1  high while in BUSY
- done  out  1  one-cycle pulse; results valid
- quotient  out  DW  registered quotient
- remainder  out  VW  registered remainder
- div_by_zero  out  1  present only with DIV_DBZ_FLAG_EN

Interface decision:
- One clock; reset is synchronous and active-low. Clock port is clk, reset port is rst_n.

Behaviour:
- Reset (rst_n=0 at a clk edge), including mid-operation: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. All internal registers are cleared and any in-flight divide is discarded.
- States are IDLE, BUSY and DONE.
- IDLE:
  - start=1 with divisor!=0: capture operands, clear partial remainder, step counter=DW-1, go to BUSY.
  - start=1 with divisor==0: go directly to DONE with quotient={DW{1}}, remainder=0.
- BUSY, each cycle:
  - pr_shift = {pr[VW-1:0], dividend_reg[msb]}, width VW+1.
  - Shift dividend_reg left by one.
  - If pr_shift >= {1'b0,divisor_reg}: pr = pr_shift - divisor, q bit=1. Otherwise pr = pr_shift, q bit=0.
  - Shift the q bit into the quotient register LSB.
  - When counter==0, go to DONE. Otherwise decrement the counter.
- DONE:
  - done=1 for exactly this cycle.
  - quotient and remainder are updated on entry to DONE and hold until the next accepted start.
  - Next state is IDLE, or BUSY if start=1 in DONE (back-to-back accepted, no dead cycle).
- busy=1 only in BUSY. start while BUSY is ignored; operands are not resampled.
- Latency: start sampled at edge N gives done=1 in the cycle after edge N+DW, so the throughput is one result per DW+1 cycles. Divide-by-zero gives done one cycle after the start edge.
- Internal partial remainder is VW+1 bits, so there is no overflow. The final remainder is always < divisor.
- Operand inputs may change freely after the accepting edge.

Optional Feature:
- Macro: DIV_DBZ_FLAG_EN.
- Defined:
  - div_by_zero port exists. It is set together with done for a zero-divisor request.
  - It holds until the next accepted start or reset.
- Undefined:
  - Port is absent. Divide-by-zero still yields quotient={DW{1}}, remainder=0, done after 1 cycle.

Decomposition:
- Package div_pkg holds:
  - state enum div_state_t {IDLE, BUSY, DONE}
  - default width constants DIV_DW=8, DIV_VW=4
  - a counter-width helper (clog2 of DW)
- One natural sub-module: div_restore_step. It is combinational and performs one shift/compare/subtract, taking pr, the incoming bit and the divisor, and returning next pr and the q bit.
- The top level holds the FSM, counter and registers.

Test Plan:
- 200/7: start one cycle -> busy for 8 cycles, done on cycle 9 after start edge, quotient=28, remainder=4.
- 255/1 then 5/9 back-to-back, start held in DONE -> q=255 r=0, then q=0 r=5. Second busy begins the cycle after the first done.
- 0/0 and 17/0 -> done 1 cycle after start, quotient=8'hFF, remainder=0, div_by_zero=1 when DIV_DBZ_FLAG_EN is defined.
- 144/12 started, then start=1 with 99/3 pulsed at cycle 3 of BUSY -> ignored, result q=12 r=0.
- rst_n=0 at cycle 4 of 200/7 -> next cycle all outputs 0, state IDLE. A subsequent 100/10 gives q=10 r=0.
- Random sweep of all 8-bit dividends x 4-bit divisors 1..15 against the reference model q=a/b, r=a%b. Check that done occurs exactly once per accepted start.
